// File: rtl/sum_accumulator_if.sv
// Handshake bundle between the adder stage, the sum accumulator and its downstream consumer.
// The slave view belongs to the accumulator; the master view belongs to whoever drives it.
interface sum_accumulator_if #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
);
  localparam int ACC_W = WIDTH + 1 + $clog2(COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH:0]   in_sum;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_total;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_sum, flush, out_ready,
    output in_ready, out_valid, out_total, out_count
  );

  modport master (
    output in_valid, in_sum, flush, out_ready,
    input  in_ready, out_valid, out_total, out_count
  );
endinterface

// File: rtl/sum_accumulator.sv
// Accumulates COUNT adder sums (or fewer on flush) into one block total and holds it on a
// ready/valid port, back-pressuring the adder until the total is taken.
module sum_accumulator #(
  parameter int WIDTH = 32,
  parameter int COUNT = 4
) (
  input  logic               clk,
  input  logic               rst,
  sum_accumulator_if.slave   bus
);
  localparam int ACC_W = WIDTH + 1 + $clog2(COUNT);
  localparam int CNT_W = $clog2(COUNT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(COUNT - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state, state_next;
  logic [ACC_W-1:0] acc, acc_next, sum_total, total_q;
  logic [CNT_W-1:0] cnt, cnt_next, sum_count, count_q;
  logic [ACC_W-1:0] sum_ext;
  logic             beat;
  logic             close;

  assign beat      = bus.in_valid && (state == ACCUM);
  assign sum_ext   = {{(ACC_W-WIDTH-1){1'b0}}, bus.in_sum};
  assign sum_total = acc + (beat ? sum_ext : '0);
  assign sum_count = cnt + CNT_W'(beat);

  // NOTE: every signal written here gets a default first so no path leaves it unassigned,
  // which is what keeps synthesis from inferring latches.
  always_comb begin
    state_next = state;
    acc_next   = acc;
    cnt_next   = cnt;
    close      = 1'b0;
    case (state)
      ACCUM: begin
        acc_next = sum_total;
        cnt_next = sum_count;
        if ((beat && cnt == LAST) || (bus.flush && (cnt != '0 || beat))) begin
          close      = 1'b1;
          state_next = HOLD;
          acc_next   = '0;
          cnt_next   = '0;
        end
      end
      HOLD: begin
        if (bus.out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ACCUM;
    else      state <= state_next;
  end

  // Output registers only load when a block closes, so the last total stays visible.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc     <= '0;
      cnt     <= '0;
      total_q <= '0;
      count_q <= '0;
    end else begin
      acc <= acc_next;
      cnt <= cnt_next;
      if (close) begin
        total_q <= sum_total;
        count_q <= sum_count;
      end
    end
  end

  assign bus.in_ready  = (state == ACCUM);
  assign bus.out_valid = (state == HOLD);
  assign bus.out_total = total_q;
  assign bus.out_count = count_q;
endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios with literal expectations plus
// a randomized run, all compared each cycle against a queue-based block model.
module tb_sum_accumulator;
  localparam int WIDTH = 32;
  localparam int COUNT = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  sum_accumulator_if #(.WIDTH(WIDTH), .COUNT(COUNT)) bus ();

  sum_accumulator #(.WIDTH(WIDTH), .COUNT(COUNT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a block is the list of accepted sums; it closes on the COUNTth
  // sum or on a flush with a non-empty list, then waits for the consumer.
  longint q[$];
  bit     m_hold;
  longint m_total;
  int     m_count;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      m_hold  = 1'b0;
      m_total = 0;
      m_count = 0;
    end else if (m_hold) begin
      if (bus.out_ready) m_hold = 1'b0;
    end else begin
      if (bus.in_valid) q.push_back(longint'(bus.in_sum));
      if (q.size() == COUNT || (bus.flush && q.size() > 0)) begin
        m_total = 0;
        foreach (q[i]) m_total += q[i];
        m_count = q.size();
        q.delete();
        m_hold  = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (rst) begin
      check("in_ready",  64'(bus.in_ready),  64'(!m_hold));
      check("out_valid", 64'(bus.out_valid), 64'(m_hold));
      check("out_total", 64'(bus.out_total), 64'(m_total));
      check("out_count", 64'(bus.out_count), 64'(m_count));
    end
  end

  task automatic drive(input bit v, input logic [WIDTH:0] s, input bit f, input bit r);
    bus.in_valid  = v;
    bus.in_sum    = s;
    bus.flush     = f;
    bus.out_ready = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH:0] rs;
    bus.in_valid = 0; bus.in_sum = '0; bus.flush = 0; bus.out_ready = 1;

    // 1: reset state
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    rst = 1'b1;
    drive(0, 0, 0, 1);
    check("rst_in_ready",  64'(bus.in_ready),  64'd1);
    check("rst_out_valid2", 64'(bus.out_valid), 64'd0);
    check("rst_out_total", 64'(bus.out_total), 64'd0);
    check("rst_out_count", 64'(bus.out_count), 64'd0);

    // 2: full block, consumer always ready
    drive(1, 2024, 0, 1);
    drive(1, 500, 0, 1);
    drive(1, 100, 0, 1);
    check("t2_no_early_valid", 64'(bus.out_valid), 64'd0);
    drive(1, 76, 0, 1);
    check("t2_valid", 64'(bus.out_valid), 64'd1);
    check("t2_total", 64'(bus.out_total), 64'd2700);
    check("t2_count", 64'(bus.out_count), 64'd4);
    drive(0, 0, 0, 1);
    check("t2_valid_one_cycle", 64'(bus.out_valid), 64'd0);

    // 3: back-pressure with in_valid kept high
    drive(1, 2024, 0, 0);
    drive(1, 500, 0, 0);
    drive(1, 100, 0, 0);
    drive(1, 76, 0, 0);
    for (int i = 0; i < 5; i++) begin
      drive(1, WIDTH'(1000 + i), 0, 0);
      check("t3_hold_total", 64'(bus.out_total), 64'd2700);
      check("t3_in_ready",   64'(bus.in_ready),  64'd0);
    end
    drive(1, 999, 0, 1);
    check("t3_ready_after_hs", 64'(bus.in_ready), 64'd1);
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 1);
    drive(1, 1, 0, 1);
    check("t3_next_block", 64'(bus.out_total), 64'd4);
    drive(0, 0, 0, 1);

    // 4: flush paths
    drive(1, 200, 0, 1);
    drive(1, 300, 0, 1);
    drive(0, 0, 1, 1);
    check("t4_flush_total", 64'(bus.out_total), 64'd500);
    check("t4_flush_count", 64'(bus.out_count), 64'd2);
    drive(0, 0, 0, 1);
    drive(1, 7, 0, 1);
    drive(1, 10, 1, 1);
    check("t4_beat_flush_total", 64'(bus.out_total), 64'd17);
    check("t4_beat_flush_count", 64'(bus.out_count), 64'd2);
    drive(0, 0, 0, 1);
    drive(0, 0, 1, 1);
    check("t4_idle_flush", 64'(bus.out_valid), 64'd0);

    // 5: maximum sums do not wrap
    for (int i = 0; i < 4; i++) drive(1, '1, 0, 1);
    check("t5_max_total", 64'(bus.out_total), 64'h7_FFFF_FFFC);
    check("t5_max_count", 64'(bus.out_count), 64'd4);
    drive(0, 0, 0, 1);

    // 6: reset mid-block and during HOLD
    drive(1, 5, 0, 1);
    drive(1, 5, 0, 1);
    bus.in_valid = 0;
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) drive(1, 1, 0, 1);
    check("t6_discard_total", 64'(bus.out_total), 64'd4);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) drive(1, 3, 0, 0);
    check("t6_hold_valid", 64'(bus.out_valid), 64'd1);
    bus.in_valid = 0;
    rst = 1'b0;
    #1;
    check("t6_async_drop", 64'(bus.out_valid), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    drive(0, 0, 0, 1);

    // Randomized run
    for (int n = 0; n < 3000; n++) begin
      rs[WIDTH-1:0] = $urandom;
      rs[WIDTH]     = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) rs = '1;
      drive(1'($urandom_range(0, 3) != 0), rs, ($urandom_range(0, 9) == 0),
            ($urandom_range(0, 2) != 0));
    end
    repeat (3) drive(0, 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
